// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes on both sides.
// Stage 0 captures the combinational result; the last stage drives the outputs.
// A stage may load whenever it is empty or the stage below it is moving, so
// bubbles collapse and a full pipeline can accept and deliver in the same cycle.
module alu_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             zero,
  output logic             carry
);

  localparam int unsigned ShW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Result of the beat currently offered on the input
  logic [ShW-1:0]   shamt;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_z;

  // Per-stage state
  logic [LATENCY-1:0] v_q;
  logic [LATENCY-1:0] z_q;
  logic [LATENCY-1:0] c_q;
  logic [WIDTH-1:0]   s_q [LATENCY];
  logic [LATENCY-1:0] adv;

  // Operation decode and flag generation for the offered operands
  always_comb begin
    shamt   = b[ShW-1:0];
    sum_ext = {1'b0, a} + {1'b0, b};
    res     = '0;
    res_c   = 1'b0;
    unique case (op)
      3'b000: begin
        res   = sum_ext[WIDTH-1:0];
        res_c = sum_ext[WIDTH];
      end
      3'b001: begin
        res   = a - b;
        res_c = (a < b);
      end
      3'b010: res = a & b;
      3'b011: res = a | b;
      3'b100: res = a ^ b;
      3'b101: res = a << shamt;
      3'b110: res = a >> shamt;
      3'b111: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
    endcase
    res_z = (res == '0);
  end

  // Stage i moves unless it and every stage below it is full and the consumer stalls.
  // Written as a flat reduction rather than a chain to keep the ready path free of
  // self-referencing vector bits.
  always_comb begin
    for (int i = 0; i < int'(LATENCY); i++) begin
      adv[i] = out_ready;
      for (int j = i; j < int'(LATENCY); j++) begin
        if (!v_q[j]) adv[i] = 1'b1;
      end
    end
  end

  // Pipeline registers: load from upstream whenever the stage advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      z_q <= '0;
      c_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        s_q[i] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v_q[0] <= in_valid;
        if (in_valid) begin
          s_q[0] <= res;
          z_q[0] <= res_z;
          c_q[0] <= res_c;
        end
      end
      for (int i = 1; i < int'(LATENCY); i++) begin
        if (adv[i]) begin
          v_q[i] <= v_q[i-1];
          // Payload only follows real beats; bubbles leave it untouched
          if (v_q[i-1]) begin
            s_q[i] <= s_q[i-1];
            z_q[i] <= z_q[i-1];
            c_q[i] <= c_q[i-1];
          end
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[LATENCY-1];
  assign s         = s_q[LATENCY-1];
  assign zero      = z_q[LATENCY-1];
  assign carry     = c_q[LATENCY-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed checks on a 32-bit/2-stage instance and random
// traffic on 8-bit instances with 1 and 5 stages, all scored against a queue model.
module tb_alu_pipe;

  logic clk;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   r_start = 0;
  bit   r_done = 0;

  logic rst_p, rst_r;

  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_zero, p_carry;
  logic [31:0] p_a, p_b, p_s;
  logic [2:0]  p_op;

  logic        r1_in_valid, r1_in_ready, r1_out_valid, r1_out_ready, r1_zero, r1_carry;
  logic [7:0]  r1_a, r1_b, r1_s;
  logic [2:0]  r1_op;

  logic        r5_in_valid, r5_in_ready, r5_out_valid, r5_out_ready, r5_zero, r5_carry;
  logic [7:0]  r5_a, r5_b, r5_s;
  logic [2:0]  r5_op;

  // {carry, zero, s[31:0]}
  logic [33:0] exp_p [$];
  logic [33:0] exp_1 [$];
  logic [33:0] exp_5 [$];
  int          pop_cyc_p [$];

  alu_pipe #(.WIDTH(32), .LATENCY(2)) u_dut_p (
    .clk(clk), .rst(rst_p), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .a(p_a), .b(p_b), .op(p_op), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .s(p_s), .zero(p_zero), .carry(p_carry)
  );

  alu_pipe #(.WIDTH(8), .LATENCY(1)) u_dut_r1 (
    .clk(clk), .rst(rst_r), .in_valid(r1_in_valid), .in_ready(r1_in_ready),
    .a(r1_a), .b(r1_b), .op(r1_op), .out_valid(r1_out_valid), .out_ready(r1_out_ready),
    .s(r1_s), .zero(r1_zero), .carry(r1_carry)
  );

  alu_pipe #(.WIDTH(8), .LATENCY(5)) u_dut_r5 (
    .clk(clk), .rst(rst_r), .in_valid(r5_in_valid), .in_ready(r5_in_ready),
    .a(r5_a), .b(r5_b), .op(r5_op), .out_valid(r5_out_valid), .out_ready(r5_out_ready),
    .s(r5_s), .zero(r5_zero), .carry(r5_carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU on w-bit unsigned arithmetic
  function automatic logic [33:0] model(input int unsigned w, input logic [31:0] a,
                                        input logic [31:0] b, input logic [2:0] op);
    longint unsigned m, ua, ub, r, sh;
    longint          sa, sb;
    logic            c;
    m  = (64'd1 << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sh = ub % w;
    c  = 1'b0;
    sa = ((ua >> (w - 1)) & 1) != 0 ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb = ((ub >> (w - 1)) & 1) != 0 ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    case (op)
      3'd0: begin r = ua + ub; c = ((r >> w) & 1) != 0; end
      3'd1: begin r = ua - ub; c = (ua < ub); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = ua << sh;
      3'd6: r = ua >> sh;
      default: r = (sa < sb) ? 1 : 0;
    endcase
    r = r & m;
    return {c, (r == 0), r[31:0]};
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      3:       return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  // Scoreboard monitors: compare every consumed result against the model queue
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (!rst_p && p_out_valid && p_out_ready) begin
        if (exp_p.size() == 0) check("p_unexpected_out", 64'(p_out_valid), 64'd0);
        else begin
          e = exp_p.pop_front();
          check("p_result", 64'({p_carry, p_zero, p_s}), 64'({e[33], e[32], e[31:0]}));
          pop_cyc_p.push_back(cyc);
        end
      end
    end
  end

  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (!rst_r && r1_out_valid && r1_out_ready) begin
        if (exp_1.size() == 0) check("r1_unexpected_out", 64'(r1_out_valid), 64'd0);
        else begin
          e = exp_1.pop_front();
          check("r1_result", 64'({r1_carry, r1_zero, r1_s}), 64'({e[33], e[32], e[7:0]}));
        end
      end
    end
  end

  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (!rst_r && r5_out_valid && r5_out_ready) begin
        if (exp_5.size() == 0) check("r5_unexpected_out", 64'(r5_out_valid), 64'd0);
        else begin
          e = exp_5.pop_front();
          check("r5_result", 64'({r5_carry, r5_zero, r5_s}), 64'({e[33], e[32], e[7:0]}));
        end
      end
    end
  end

  // Offer one beat to the 32-bit instance; call and return at posedge+1
  task automatic issue_p(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input int max_wait, output bit ok, output int acc, output int waits);
    p_a = a; p_b = b; p_op = op; p_in_valid = 1'b1;
    ok = 1'b0; acc = -1; waits = 0;
    for (int k = 0; k <= max_wait; k++) begin
      @(negedge clk);
      if (p_in_ready) begin
        exp_p.push_back(model(32, a, b, op));
        ok  = 1'b1;
        acc = cyc;
      end
      @(posedge clk); #1;
      if (ok) break;
      waits++;
    end
    p_in_valid = 1'b0;
  endtask

  // Single beat into an empty pipe with out_ready=1: check latency and values
  task automatic run_direct(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input logic [31:0] es, input logic ec,
                            input logic ez);
    bit ok;
    int acc, w;
    issue_p(a, b, op, 4, ok, acc, w);
    check({name, "_accept"}, 64'(ok), 64'd1);
    @(negedge clk);
    check({name, "_early_valid"}, 64'(p_out_valid), 64'd0);
    @(negedge clk);
    check({name, "_valid"}, 64'(p_out_valid), 64'd1);
    check({name, "_s"}, 64'(p_s), 64'(es));
    check({name, "_carry"}, 64'(p_carry), 64'(ec));
    check({name, "_zero"}, 64'(p_zero), 64'(ez));
    @(posedge clk); #1;
  endtask

  task automatic drain_p();
    for (int k = 0; k < 30 && exp_p.size() != 0; k++) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // Random traffic on the 8-bit instances
  initial begin
    bit h1, h5;
    h1 = 1'b0; h5 = 1'b0;
    wait (r_start);
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      if (!h1) begin
        r1_in_valid = ($urandom_range(0, 3) != 0);
        r1_a = pick8(); r1_b = pick8(); r1_op = 3'($urandom_range(0, 7));
      end
      if (!h5) begin
        r5_in_valid = ($urandom_range(0, 3) != 0);
        r5_a = pick8(); r5_b = pick8(); r5_op = 3'($urandom_range(0, 7));
      end
      r1_out_ready = ($urandom_range(0, 3) != 0);
      // Periodic long stalls let the deep pipe fill completely
      r5_out_ready = ((c % 100) < 20) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (r1_in_valid && r1_in_ready) begin
        exp_1.push_back(model(8, {24'd0, r1_a}, {24'd0, r1_b}, r1_op));
        h1 = 1'b0;
      end else h1 = r1_in_valid;
      if (r5_in_valid && r5_in_ready) begin
        exp_5.push_back(model(8, {24'd0, r5_a}, {24'd0, r5_b}, r5_op));
        h5 = 1'b0;
      end else h5 = r5_in_valid;
    end
    @(posedge clk); #1;
    r1_in_valid = 1'b0; r5_in_valid = 1'b0;
    r1_out_ready = 1'b1; r5_out_ready = 1'b1;
    for (int k = 0; k < 40 && (exp_1.size() != 0 || exp_5.size() != 0); k++) @(posedge clk);
    #1;
    check("r1_left_in_flight", 64'(exp_1.size()), 64'd0);
    check("r5_left_in_flight", 64'(exp_5.size()), 64'd0);
    r_done = 1'b1;
  end

  initial begin
    bit          ok;
    int          acc, w, first, stalls, stale;
    rst_p = 1'b1; rst_r = 1'b1;
    p_in_valid = 1'b0; p_out_ready = 1'b0; p_a = '0; p_b = '0; p_op = '0;
    r1_in_valid = 1'b0; r1_out_ready = 1'b0; r1_a = '0; r1_b = '0; r1_op = '0;
    r5_in_valid = 1'b0; r5_out_ready = 1'b0; r5_a = '0; r5_b = '0; r5_op = '0;

    // Reset state
    @(posedge clk); #1;
    check("rst_out_valid", 64'(p_out_valid), 64'd0);
    check("rst_s", 64'(p_s), 64'd0);
    check("rst_zero", 64'(p_zero), 64'd0);
    check("rst_carry", 64'(p_carry), 64'd0);
    check("rst_r5_out_valid", 64'(r5_out_valid), 64'd0);
    @(posedge clk); #1;
    rst_p = 1'b0; rst_r = 1'b0;
    r_start = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 64'(p_in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed ops
    p_out_ready = 1'b1;
    run_direct("add_wrap", 32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 1'b1, 1'b1);
    run_direct("sub_borrow", 32'd3, 32'd5, 3'b001, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_direct("slt_neg", 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0);
    run_direct("shl_mod", 32'd1, 32'h23, 3'b101, 32'd8, 1'b0, 1'b0);
    run_direct("shr_msb", 32'h8000_0000, 32'd31, 3'b110, 32'd1, 1'b0, 1'b0);
    run_direct("and", 32'hA5A5_A5A5, 32'h0F0F_0F0F, 3'b010, 32'h0505_0505, 1'b0, 1'b0);
    run_direct("or", 32'h0000_00F0, 32'h0000_000F, 3'b011, 32'h0000_00FF, 1'b0, 1'b0);
    run_direct("xor_self", 32'h1234_5678, 32'h1234_5678, 3'b100, 32'd0, 1'b0, 1'b1);

    // Back-to-back stream
    pop_cyc_p.delete();
    stalls = 0; first = 0;
    for (int i = 0; i < 10; i++) begin
      issue_p(32'(i), 32'(i), 3'b000, 4, ok, acc, w);
      if (i == 0) first = acc;
      stalls += w;
    end
    drain_p();
    check("stream_stalls", 64'(stalls), 64'd0);
    check("stream_count", 64'(pop_cyc_p.size()), 64'd10);
    foreach (pop_cyc_p[k]) check("stream_cycle", 64'(pop_cyc_p[k]), 64'(first + 2 + k));

    // Backpressure: two beats buffer, third refused, then drain in order
    pop_cyc_p.delete();
    p_out_ready = 1'b0;
    issue_p(32'd10, 32'd1, 3'b000, 0, ok, acc, w);
    check("bp_beat1_accept", 64'(ok), 64'd1);
    issue_p(32'd20, 32'd2, 3'b001, 0, ok, acc, w);
    check("bp_beat2_accept", 64'(ok), 64'd1);
    issue_p(32'd30, 32'd3, 3'b100, 3, ok, acc, w);
    check("bp_beat3_refused", 64'(ok), 64'd0);
    check("bp_in_ready_low", 64'(p_in_ready), 64'd0);
    check("bp_out_valid_held", 64'(p_out_valid), 64'd1);
    check("bp_s_held", 64'(p_s), 64'd11);
    p_out_ready = 1'b1;
    issue_p(32'd30, 32'd3, 3'b100, 10, ok, acc, w);
    check("bp_beat3_accept", 64'(ok), 64'd1);
    issue_p(32'd40, 32'd4, 3'b011, 10, ok, acc, w);
    check("bp_beat4_accept", 64'(ok), 64'd1);
    drain_p();
    check("bp_delivered", 64'(pop_cyc_p.size()), 64'd4);

    // Reset with beats in flight
    p_out_ready = 1'b0;
    issue_p(32'd1, 32'd1, 3'b000, 2, ok, acc, w);
    issue_p(32'd2, 32'd2, 3'b000, 2, ok, acc, w);
    #2;
    rst_p = 1'b1;
    exp_p.delete();
    #1;
    check("mid_rst_out_valid", 64'(p_out_valid), 64'd0);
    check("mid_rst_s", 64'(p_s), 64'd0);
    check("mid_rst_flags", 64'({p_zero, p_carry}), 64'd0);
    @(posedge clk); #1;
    rst_p = 1'b0;
    p_out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(p_in_ready), 64'd1);
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      if (p_out_valid) stale++;
      @(negedge clk);
    end
    check("post_rst_no_stale", 64'(stale), 64'd0);
    @(posedge clk); #1;
    run_direct("post_rst_add", 32'd2, 32'd3, 3'b000, 32'd5, 1'b0, 1'b0);

    for (int k = 0; k < 5000 && !r_done; k++) @(posedge clk);
    check("rand_finished", 64'(r_done), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
